// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : State encoding, opcode and ALUOp constants for mc_controller.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [6:0] op);
    if (op == OP_RTYPE) return ALUOP_R;
    if (op == OP_ITYPE) return ALUOP_I;
    return ALUOP_ADD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts cycles spent waiting on mem_ready; flags timeout at MEM_WAIT_MAX.
// Revision : 1.0
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] c_MAX = 8'(MEM_WAIT_MAX);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (count_en && !mem_ready && (r_count != c_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // A completing handshake in the limit cycle never counts as a timeout.
  assign timeout = count_en && !mem_ready && (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Multi-cycle RV32I control sequencer with memory watchdog and
//            retired-instruction counter. Option macro: ILLEGAL_TRAP_EN.
// Revision : 1.0
// ============================================================================
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             mem_err,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_insn,
`endif
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_retire;
  logic             w_illegal_set;
  logic             w_timeout;
  logic             w_wait_en;
  logic             w_is_load;
  logic             w_is_mem;
  logic [CNT_W-1:0] r_retired;

  assign w_is_load = (opcode == OP_LOAD);
  assign w_is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign w_wait_en = (r_state == ST_FETCH) || (r_state == ST_MEM);

  // Any state change restarts the wait count, so FETCH/MEM always begin at zero.
  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_state_next != r_state),
    .count_en  (w_wait_en),
    .mem_ready (mem_ready),
    .timeout   (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_retire      = 1'b0;
    w_illegal_set = 1'b0;
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem2reg       = 1'b0;
    mem_err       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode)) begin
          w_state_next = ST_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_state_next  = ST_ERROR;
          w_illegal_set = 1'b1;
`else
          w_state_next = ST_FETCH;
          w_retire     = 1'b1;
`endif
        end
      end
      ST_EXECUTE: begin
        alu_src      = (opcode != OP_RTYPE);
        alu_op       = alu_op_for(opcode);
        w_state_next = w_is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        alu_src   = 1'b1;
        mem_read  = w_is_load;
        mem_write = !w_is_load;
        if (mem_ready) begin
          w_state_next = w_is_load ? ST_WB : ST_FETCH;
          w_retire     = !w_is_load;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_WB: begin
        reg_write    = 1'b1;
        mem2reg      = w_is_load;
        alu_src      = (opcode != OP_RTYPE);
        alu_op       = alu_op_for(opcode);
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_ERROR: mem_err = 1'b1;
      default:  w_state_next = ST_IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_illegal <= 1'b0;
    else if (w_illegal_set) r_illegal <= 1'b1;
  end
  assign illegal_insn = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal_set;
`endif

  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Directed self-checking bench for mc_controller (MEM_WAIT_MAX=4).
// Revision : 1.0
// ============================================================================
module tb_mc_controller;
  import ctrl_pkg::*;

  localparam int CNT_W = 32;

  // Output vector: {mem_req,iord,mem_read,mem_write,ir_write,pc_write,alu_src,alu_op,reg_write,mem2reg,mem_err}
  localparam logic [11:0] O_IDLE       = 12'b0000_0000_0000;
  localparam logic [11:0] O_FETCH_RDY  = 12'b1010_1100_0000;
  localparam logic [11:0] O_FETCH_WAIT = 12'b1010_0000_0000;
  localparam logic [11:0] O_EX_R       = 12'b0000_0001_0000;
  localparam logic [11:0] O_WB_R       = 12'b0000_0001_0100;
  localparam logic [11:0] O_EX_I       = 12'b0000_0011_1000;
  localparam logic [11:0] O_WB_I       = 12'b0000_0011_1100;
  localparam logic [11:0] O_EX_MEM     = 12'b0000_0010_0000;
  localparam logic [11:0] O_MEM_LW     = 12'b1110_0010_0000;
  localparam logic [11:0] O_WB_LW      = 12'b0000_0010_0110;
  localparam logic [11:0] O_MEM_SW     = 12'b1101_0010_0000;
  localparam logic [11:0] O_ERR        = 12'b0000_0000_0001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             mem_ready = 1'b0;
  logic             mem_req, iord, mem_read, mem_write, ir_write, pc_write;
  logic             alu_src, reg_write, mem2reg, mem_err;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_insn;
`endif
  logic [11:0]      w_outs;

  int checks = 0;
  int errors = 0;

  mc_controller #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem2reg      (mem2reg),
    .mem_err      (mem_err),
`ifdef ILLEGAL_TRAP_EN
    .illegal_insn (illegal_insn),
`endif
    .retired      (retired)
  );

  assign w_outs = {mem_req, iord, mem_read, mem_write, ir_write, pc_write,
                   alu_src, alu_op, reg_write, mem2reg, mem_err};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("reset_outs", 32'(w_outs), 32'(O_IDLE));
    chk("reset_retired", retired, 32'd0);

    // R-type with memory always ready
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE; #1;
    chk("idle_outs", 32'(w_outs), 32'(O_IDLE));
    step(); chk("r_fetch", 32'(w_outs), 32'(O_FETCH_RDY));
    step(); chk("r_decode", 32'(w_outs), 32'(O_IDLE));
    chk("r_decode_state", 32'(dut.r_state), 32'(ST_DECODE));
    step(); chk("r_execute", 32'(w_outs), 32'(O_EX_R));
    step(); chk("r_wb", 32'(w_outs), 32'(O_WB_R));
    step(); chk("r_back_fetch", 32'(w_outs), 32'(O_FETCH_RDY));
    chk("r_retired", retired, 32'd1);

    // I-type
    opcode = OP_ITYPE;
    step(); chk("i_decode", 32'(w_outs), 32'(O_IDLE));
    step(); chk("i_execute", 32'(w_outs), 32'(O_EX_I));
    step(); chk("i_wb", 32'(w_outs), 32'(O_WB_I));
    step(); chk("i_retired", retired, 32'd2);

    // LW with mem_ready low for 3 MEM cycles
    opcode = OP_LOAD;
    step(); chk("lw_decode", 32'(w_outs), 32'(O_IDLE));
    step(); chk("lw_execute", 32'(w_outs), 32'(O_EX_MEM));
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_wait", 32'(w_outs), 32'(O_MEM_LW));
      step();
    end
    mem_ready = 1'b1; #1;
    chk("lw_mem_done", 32'(w_outs), 32'(O_MEM_LW));
    step(); chk("lw_wb", 32'(w_outs), 32'(O_WB_LW));
    step(); chk("lw_retired", retired, 32'd3);
    chk("lw_no_err", 32'(mem_err), 32'd0);

    // SW goes MEM -> FETCH without WB
    opcode = OP_STORE;
    step(); step(); chk("sw_execute", 32'(w_outs), 32'(O_EX_MEM));
    step(); chk("sw_mem", 32'(w_outs), 32'(O_MEM_SW));
    step(); chk("sw_back_fetch", 32'(w_outs), 32'(O_FETCH_RDY));
    chk("sw_retired", retired, 32'd4);

    // Asynchronous reset while MEM holds mem_req
    opcode = OP_LOAD;
    step(); step(); mem_ready = 1'b0;
    step(); chk("rst_mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0; #1;
    chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rst_outs", 32'(w_outs), 32'(O_IDLE));
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_retired", retired, 32'd0);

    // Unrecognised opcode
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'h7F;
    step(); step(); chk("ill_decode", 32'(w_outs), 32'(O_IDLE));
    step();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_error", 32'(w_outs), 32'(O_ERR));
    chk("ill_flag", 32'(illegal_insn), 32'd1);
`else
    chk("ill_nop_fetch", 32'(w_outs), 32'(O_FETCH_RDY));
    chk("ill_nop_retired", retired, 32'd1);
`endif

    // Watchdog expiry in FETCH: 5 waiting cycles, then ERROR
    reset = 1'b0; #1; reset = 1'b1; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("wd_fetch_wait", 32'(w_outs), 32'(O_FETCH_WAIT));
      step();
    end
    chk("wd_error_outs", 32'(w_outs), 32'(O_ERR));
    chk("wd_error_state", 32'(dut.r_state), 32'(ST_ERROR));
    mem_ready = 1'b1;
    step(); step();
    chk("wd_error_sticky", 32'(w_outs), 32'(O_ERR));

    // mem_ready arriving exactly on the limit cycle wins
    reset = 1'b0; #1; reset = 1'b1; mem_ready = 1'b0; opcode = OP_RTYPE;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("wd2_fetch_wait", 32'(w_outs), 32'(O_FETCH_WAIT));
      step();
    end
    mem_ready = 1'b1; #1;
    chk("wd2_limit_ready", 32'(w_outs), 32'(O_FETCH_RDY));
    step();
    chk("wd2_decode_state", 32'(dut.r_state), 32'(ST_DECODE));
    chk("wd2_no_err", 32'(mem_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control sequencer for the RV32I datapath.
- Replaces the single-cycle Controller: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB over one shared, handshaked memory port.
- Drives the existing datapath enables (reg_write, mem2reg, alu_src, mem_read, mem_write) and ALUOp into ALUController.
- Adds a memory-wait watchdog and a retired-instruction counter.

Parameters:
MEM_WAIT_MAX, 15, cycles mem_ready may stay low in FETCH/MEM before the error trap; legal range 1..255
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  7  opcode field from the datapath instruction register
mem_ready  in  1  memory handshake completion
mem_req  out  1  memory request, held until mem_ready
iord  out  1  0 = instruction address (PC), 1 = data address (ALU result)
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
ir_write  out  1  load instruction register
pc_write  out  1  PC <= PC+4
alu_src  out  1  ALU operand B = immediate
alu_op  out  2  to ALUController: 00 add (LW/SW), 10 R-type, 11 I-type ALU
reg_write  out  1  register-file write
mem2reg  out  1  write-back source = memory data
mem_err  out  1  sticky watchdog error
retired  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, ERROR.
- Reset asserted: state = IDLE; wait counter = 0; retired = 0; mem_err = 0.
- All outputs are 0 in IDLE. Reset takes effect immediately mid-operation: mem_req drops in the same cycle.
- Outputs are a Moore decode of state, except ir_write/pc_write, which also depend on mem_ready.
- IDLE -> FETCH on the first clock after reset is released.
- FETCH:
  - Drives mem_req=1, mem_read=1, iord=0.
  - If mem_ready=1: ir_write=1 and pc_write=1 in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no outputs. Next state EXECUTE for opcodes 0110011 (R), 0010011 (I), 0000011 (LW), 0100011 (SW).
- Any other opcode: handled per Optional Feature.
- EXECUTE: one cycle.
  - R: alu_src=0, alu_op=10.
  - I: alu_src=1, alu_op=11.
  - LW/SW: alu_src=1, alu_op=00.
  - Next state: MEM for LW/SW, else WB.
- MEM:
  - Drives mem_req=1, iord=1, alu_src=1, alu_op=00; mem_read=1 for LW, mem_write=1 for SW.
  - On mem_ready=1: LW -> WB; SW -> FETCH and retires.
  - Otherwise stay in MEM.
- WB: one cycle with reg_write=1 (mem2reg=1 only for LW), alu_src/alu_op held as in EXECUTE. Next state FETCH; retires.
- Retire: retired increments by 1 on the retiring clock edge and wraps modulo 2^CNT_W.
- Watchdog:
  - The counter clears on entry to FETCH or MEM.
  - It increments each cycle in FETCH/MEM while mem_ready=0.
  - When it equals MEM_WAIT_MAX with mem_ready still 0, the next state is ERROR.
  - mem_ready=1 in that same cycle wins: normal transition, no error.
- ERROR: all enables 0, mem_err=1; absorbing until reset.
- The opcode input is sampled only in DECODE/EXECUTE/MEM/WB; the IR stays stable there because ir_write is 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE moves to ERROR and asserts mem_err plus an extra output illegal_insn (1 bit, sticky until reset).
- Not defined: an unrecognised opcode is treated as a NOP. DECODE -> FETCH, retired increments, no register or memory side effect, and the illegal_insn port is absent.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum (3-bit encoding);
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE;
  - ALUOp constants ALUOP_ADD, ALUOP_R, ALUOP_I.
- One sub-module, mem_wait_timer, contains the watchdog counter.
  - Inputs: clear, count_en, mem_ready.
  - Output: timeout.
  - Parameter: MEM_WAIT_MAX.

Test Plan:
- Reset low 3 cycles, release, mem_ready=1 always, opcode=0110011 → IDLE, FETCH, DECODE, EXECUTE (alu_op=10, alu_src=0), WB (reg_write=1, mem2reg=0), FETCH; retired=1 after 5 cycles from FETCH.
- LW (0000011) with mem_ready delayed 3 cycles in MEM → mem_req/mem_read/iord held 4 cycles, then WB with mem2reg=1; retired +1; mem_err=0.
- SW (0100011) → MEM drives mem_write=1, iord=1, mem_read=0; mem_ready=1 gives FETCH next with no WB; reg_write never 1.
- Watchdog with MEM_WAIT_MAX=4 and mem_ready held 0 in FETCH → ERROR entered at the counter-equals-4 cycle, mem_err=1 sticky, all enables 0. Repeat with mem_ready=1 on that exact cycle → DECODE, no error.
- Assert reset while in MEM with mem_req=1 → mem_req=0 in the same cycle; state IDLE; retired=0.
- opcode=1111111 → with ILLEGAL_TRAP_EN: ERROR, illegal_insn=1. Without it: return to FETCH and retired +1.
